// File: rtl/attn_pkg.sv
// attn_pkg: shared sizes, stream tag encodings and loader state encoding.
package attn_pkg;
    localparam int DATA_W = 16;
    localparam int WORDS  = 32;
    localparam int CNT_W  = 5;
    localparam logic [1:0] SEL_KEY   = 2'd0;
    localparam logic [1:0] SEL_QUERY = 2'd1;
    localparam logic [1:0] SEL_VALUE = 2'd2;
    typedef enum logic [2:0] {IDLE, LOAD_K, LOAD_Q, LOAD_V, ARM, RUN} state_e;
endpackage

// File: rtl/attn_word_reg.sv
// attn_word_reg: WORDS x DATA_W operand bank, one element written per enabled cycle.
module attn_word_reg
    import attn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [CNT_W-1:0]        idx,
    input  logic [DATA_W-1:0]       d,
    output logic [DATA_W*WORDS-1:0] bus
);
    logic [DATA_W*WORDS-1:0] bus_q, bus_d;
    always_comb begin
        bus_d = bus_q;
        if (we) bus_d[idx*DATA_W +: DATA_W] = d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus_q <= '0;
        else        bus_q <= bus_d;
    end
    assign bus = bus_q;
endmodule

// File: rtl/attn_operand_loader.sv
// attn_operand_loader: assembles key/query/value from a tagged word stream and sequences pe_8x8_top.
// Optional LOADER_KV_REUSE_EN: after a completed run a query-only load reuses the held key/value.
module attn_operand_loader
    import attn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    input  logic [1:0]              s_sel,
    output logic [DATA_W*WORDS-1:0] key,
    output logic [DATA_W*WORDS-1:0] query,
    output logic [DATA_W*WORDS-1:0] value,
    output logic                    core_en,
    output logic                    core_rst_n,
    input  logic                    core_done,
    output logic                    run_done,
    output logic                    err,
    input  logic                    err_clr
);
`ifdef LOADER_KV_REUSE_EN
    localparam bit KV_REUSE = 1'b1;
`else
    localparam bit KV_REUSE = 1'b0;
`endif
    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             s_ready_q, s_ready_d, core_en_q, core_en_d, core_rst_n_q, core_rst_n_d;
    logic             run_done_q, run_done_d, err_q, err_d;
    logic             kv_valid_q, kv_valid_d, reuse_q, reuse_d;
    logic             we_k, we_q, we_v, bad, accept, last, reuse_start;
    assign accept      = s_valid && s_ready_q;
    assign last        = idx_q == CNT_W'(WORDS - 1);
    assign reuse_start = KV_REUSE && state_q == IDLE && kv_valid_q && s_sel == SEL_QUERY;
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        reuse_d    = reuse_q;
        kv_valid_d = kv_valid_q;
        run_done_d = 1'b0;
        we_k       = 1'b0;
        we_q       = 1'b0;
        we_v       = 1'b0;
        bad        = 1'b0;
        case (state_q)
            IDLE, LOAD_K: if (accept) begin
                if (s_sel == SEL_KEY) begin
                    we_k    = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    state_d = last ? LOAD_Q : LOAD_K;
                    reuse_d = 1'b0;
                end else if (reuse_start) begin
                    we_q    = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    state_d = LOAD_Q;
                    reuse_d = 1'b1;
                end else bad = 1'b1;
            end
            LOAD_Q: if (accept) begin
                if (s_sel == SEL_QUERY) begin
                    we_q    = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    state_d = last ? (reuse_q ? ARM : LOAD_V) : LOAD_Q;
                end else bad = 1'b1;
            end
            LOAD_V: if (accept) begin
                if (s_sel == SEL_VALUE) begin
                    we_v    = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    state_d = last ? ARM : LOAD_V;
                end else bad = 1'b1;
            end
            ARM: state_d = RUN;
            RUN: if (core_done) begin
                state_d    = IDLE;
                run_done_d = 1'b1;
                kv_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so reset can force them all low.
        s_ready_d    = state_d inside {IDLE, LOAD_K, LOAD_Q, LOAD_V};
        core_en_d    = state_d inside {ARM, RUN};
        core_rst_n_d = state_d == RUN;
        err_d        = bad | (err_q & ~err_clr);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            s_ready_q    <= 1'b0;
            core_en_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
            run_done_q   <= 1'b0;
            err_q        <= 1'b0;
            kv_valid_q   <= 1'b0;
            reuse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            s_ready_q    <= s_ready_d;
            core_en_q    <= core_en_d;
            core_rst_n_q <= core_rst_n_d;
            run_done_q   <= run_done_d;
            err_q        <= err_d;
            kv_valid_q   <= kv_valid_d;
            reuse_q      <= reuse_d;
        end
    end
    attn_word_reg u_key   (.clk(clk), .rst_n(rst_n), .we(we_k), .idx(idx_q), .d(s_data), .bus(key));
    attn_word_reg u_query (.clk(clk), .rst_n(rst_n), .we(we_q), .idx(idx_q), .d(s_data), .bus(query));
    attn_word_reg u_value (.clk(clk), .rst_n(rst_n), .we(we_v), .idx(idx_q), .d(s_data), .bus(value));
    assign s_ready    = s_ready_q;
    assign core_en    = core_en_q;
    assign core_rst_n = core_rst_n_q;
    assign run_done   = run_done_q;
    assign err        = err_q;
endmodule
